// File: rtl/abs_diff_pipe_if.sv
// Stream bundle for abs_diff_pipe: input beat (a, b, thresh), output beat
// (diff, dist, fg), and the foreground counter clear/value.
// master = upstream/downstream driver side, slave = the abs_diff_pipe block.
interface abs_diff_pipe_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 3,
  parameter int CNT_W    = 20
);
  localparam int SUM_W = WIDTH + $clog2(CHANNELS);

  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS*WIDTH-1:0] in_a;
  logic [CHANNELS*WIDTH-1:0] in_b;
  logic [SUM_W-1:0]          in_thresh;
  logic                      out_valid;
  logic                      out_ready;
  logic [CHANNELS*WIDTH-1:0] out_diff;
  logic [SUM_W-1:0]          out_dist;
  logic                      out_fg;
  logic                      cnt_clr;
  logic [CNT_W-1:0]          fg_count;

  modport master (
    output in_valid, in_a, in_b, in_thresh, out_ready, cnt_clr,
    input  in_ready, out_valid, out_diff, out_dist, out_fg, fg_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_thresh, out_ready, cnt_clr,
    output in_ready, out_valid, out_diff, out_dist, out_fg, fg_count
  );
endinterface

// File: rtl/abs_diff_pipe.sv
// Per-channel |a-b|, reduced to L1 sum (MODE 0) or channel max (MODE 1), thresholded to a fg flag.
// Latency 2 cycles accept-to-out_valid, 1 beat/cycle; fg_count saturates at 2^CNT_W-1.
// Full backpressure: in_ready = !s1_valid | !out_valid | out_ready, stalled stages hold.
// Ports: clk, rst_n (async active-low), bus (slave): in_valid/in_ready/in_a/in_b/in_thresh,
//   out_valid/out_ready/out_diff/out_dist/out_fg, cnt_clr, fg_count.
module abs_diff_pipe #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 3,
  parameter int MODE     = 0,
  parameter int CNT_W    = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  abs_diff_pipe_if.slave  bus
);
  localparam int SUM_W = WIDTH + $clog2(CHANNELS);
  localparam int DW    = CHANNELS * WIDTH;

  logic             adv1;
  logic             adv2;
  logic             fg_xfer;
  logic [DW-1:0]    diff_c;
  logic [WIDTH-1:0] a_c;
  logic [WIDTH-1:0] b_c;
  logic [SUM_W-1:0] dist_c;
  logic [SUM_W-1:0] d_c;

  logic             s1_valid;
  logic [DW-1:0]    s1_diff;
  logic [SUM_W-1:0] s1_thresh;

  logic             out_valid_q;
  logic [DW-1:0]    out_diff_q;
  logic [SUM_W-1:0] out_dist_q;
  logic             out_fg_q;
  logic [CNT_W-1:0] fg_count_q;

  // Stage advance: an output slot frees when empty or being taken; stage 1
  // can take a new beat when empty or when it moves into stage 2.
  assign adv2 = !out_valid_q | bus.out_ready;
  assign adv1 = !s1_valid | adv2;
  assign bus.in_ready = adv1;

  // Stage 1 difference: subtract the smaller from the larger so the result
  // is exact in WIDTH bits.
  always_comb begin
    diff_c = '0;
    a_c    = '0;
    b_c    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      a_c = bus.in_a[c*WIDTH +: WIDTH];
      b_c = bus.in_b[c*WIDTH +: WIDTH];
      diff_c[c*WIDTH +: WIDTH] = (a_c >= b_c) ? (a_c - b_c) : (b_c - a_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (adv1) begin
      s1_valid <= bus.in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.in_valid && adv1) begin
      s1_diff   <= diff_c;
      s1_thresh <= bus.in_thresh;
    end
  end

  // Stage 2 reduction; SUM_W leaves room for CHANNELS full-scale diffs.
  always_comb begin
    dist_c = '0;
    d_c    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      d_c = SUM_W'(s1_diff[c*WIDTH +: WIDTH]);
      if (MODE == 0) begin
        dist_c = dist_c + d_c;
      end else if (d_c > dist_c) begin
        dist_c = d_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_diff_q  <= '0;
      out_dist_q  <= '0;
      out_fg_q    <= 1'b0;
    end else if (adv2) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        out_diff_q <= s1_diff;
        out_dist_q <= dist_c;
        out_fg_q   <= (dist_c > s1_thresh);
      end
    end
  end

  // Count foreground beats as they leave; a clear in the same cycle as a
  // counted transfer keeps that transfer.
  assign fg_xfer = out_valid_q & bus.out_ready & out_fg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fg_count_q <= '0;
    end else if (bus.cnt_clr) begin
      fg_count_q <= fg_xfer ? CNT_W'(1) : '0;
    end else if (fg_xfer && (fg_count_q != {CNT_W{1'b1}})) begin
      fg_count_q <= fg_count_q + CNT_W'(1);
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_diff  = out_diff_q;
  assign bus.out_dist  = out_dist_q;
  assign bus.out_fg    = out_fg_q;
  assign bus.fg_count  = fg_count_q;
endmodule

// File: tb/tb_abs_diff_pipe.sv
// Bench for abs_diff_pipe: three instances share one stimulus stream
// (MODE 0 / MODE 1 / MODE 0 with a 2-bit counter) and are checked in lockstep.
module tb_abs_diff_pipe;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        cnt_clr;
  logic [23:0] a_v;
  logic [23:0] b_v;
  logic [9:0]  th_v;

  int errors = 0;
  int checks = 0;

  abs_diff_pipe_if #(.WIDTH(8), .CHANNELS(3), .CNT_W(20)) if0 ();
  abs_diff_pipe_if #(.WIDTH(8), .CHANNELS(3), .CNT_W(20)) if1 ();
  abs_diff_pipe_if #(.WIDTH(8), .CHANNELS(3), .CNT_W(2))  if2 ();

  assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;  assign if2.in_valid = in_valid;
  assign if0.in_a = a_v;           assign if1.in_a = a_v;           assign if2.in_a = a_v;
  assign if0.in_b = b_v;           assign if1.in_b = b_v;           assign if2.in_b = b_v;
  assign if0.in_thresh = th_v;     assign if1.in_thresh = th_v;     assign if2.in_thresh = th_v;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready; assign if2.out_ready = out_ready;
  assign if0.cnt_clr = cnt_clr;    assign if1.cnt_clr = cnt_clr;    assign if2.cnt_clr = cnt_clr;

  abs_diff_pipe #(.WIDTH(8), .CHANNELS(3), .MODE(0), .CNT_W(20)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  abs_diff_pipe #(.WIDTH(8), .CHANNELS(3), .MODE(1), .CNT_W(20)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  abs_diff_pipe #(.WIDTH(8), .CHANNELS(3), .MODE(0), .CNT_W(2))  u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] pk(input int c0, input int c1, input int c2);
    logic [7:0] x0, x1, x2;
    x0 = 8'(c0); x1 = 8'(c1); x2 = 8'(c2);
    return {x2, x1, x0};
  endfunction

  function automatic logic [23:0] ref_diff(input logic [23:0] a, input logic [23:0] b);
    logic [23:0] r;
    int av, bv;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      av = int'(a[c*8 +: 8]);
      bv = int'(b[c*8 +: 8]);
      r[c*8 +: 8] = 8'((av > bv) ? av - bv : bv - av);
    end
    return r;
  endfunction

  function automatic logic [9:0] ref_dist(input logic [23:0] a, input logic [23:0] b, input int mode);
    logic [23:0] d;
    int s, m;
    d = ref_diff(a, b);
    s = 0; m = 0;
    for (int c = 0; c < 3; c++) begin
      s = s + int'(d[c*8 +: 8]);
      if (int'(d[c*8 +: 8]) > m) m = int'(d[c*8 +: 8]);
    end
    return 10'((mode == 0) ? s : m);
  endfunction

  // Full expected beat: {diff, dist0, fg0, dist1, fg1}
  function automatic logic [45:0] ref_beat(input logic [23:0] a, input logic [23:0] b, input logic [9:0] t);
    logic [9:0] d0, d1;
    d0 = ref_dist(a, b, 0);
    d1 = ref_dist(a, b, 1);
    return {ref_diff(a, b), d0, (d0 > t), d1, (d1 > t)};
  endfunction

  function automatic logic [45:0] obs_beat();
    return {if0.out_diff, if0.out_dist, if0.out_fg, if1.out_dist, if1.out_fg};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One beat into an empty pipe with out_ready high; returns at the negedge
  // where the result should be presented.
  task automatic beat(input logic [23:0] a, input logic [23:0] b, input logic [9:0] t);
    in_valid = 1'b1; a_v = a; b_v = b; th_v = t; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_early", if0.out_valid, 1'b0);
    step();
    @(negedge clk);
    check("lat_valid", if0.out_valid, 1'b1);
  endtask

  logic [45:0] q[$];
  logic [45:0] prev;
  logic        stall_prev;
  logic        acc;
  int          sent, rx;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    a_v = '0; b_v = '0; th_v = '0;
    #3;
    check("rst_in_ready", if0.in_ready, 1'b1);
    check("rst_out_valid", if0.out_valid, 1'b0);
    check("rst_fg_count", if0.fg_count, 20'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Basic L1 and max
    beat(pk(10, 200, 50), pk(30, 100, 50), 10'd100);
    check("basic_diff", if0.out_diff, pk(20, 100, 0));
    check("basic_dist", if0.out_dist, 10'd120);
    check("basic_fg", if0.out_fg, 1'b1);
    check("max_dist", if1.out_dist, 10'd100);
    check("max_fg_eq", if1.out_fg, 1'b0);
    step();
    check("basic_cnt", if0.fg_count, 20'd1);
    check("max_cnt0", if1.fg_count, 20'd0);
    check("basic_drain", if0.out_valid, 1'b0);

    beat(pk(10, 200, 50), pk(30, 100, 50), 10'd99);
    check("max_fg_99", if1.out_fg, 1'b1);
    step();
    check("max_cnt1", if1.fg_count, 20'd1);

    // Full-scale boundary
    beat(pk(255, 255, 255), pk(0, 0, 0), 10'd765);
    check("full_diff", if0.out_diff, pk(255, 255, 255));
    check("full_dist", if0.out_dist, 10'd765);
    check("full_fg_765", if0.out_fg, 1'b0);
    step();
    check("full_cnt", if0.fg_count, 20'd2);
    beat(pk(255, 255, 255), pk(0, 0, 0), 10'd764);
    check("full_fg_764", if0.out_fg, 1'b1);
    step();
    check("sat_cnt_3", if2.fg_count, 2'd3);
    beat(pk(0, 0, 0), pk(255, 255, 255), 10'd764);
    check("swap_diff", if0.out_diff, pk(255, 255, 255));
    check("swap_dist", if0.out_dist, 10'd765);
    check("swap_fg", if0.out_fg, 1'b1);
    step();
    beat(pk(1, 1, 1), pk(0, 0, 0), 10'd0);
    check("small_dist", if0.out_dist, 10'd3);
    step();
    check("cnt_five", if0.fg_count, 20'd5);
    check("cnt_sat", if2.fg_count, 2'd3);
    check("max_cnt2", if1.fg_count, 20'd2);

    // Asynchronous reset with two beats in flight
    out_ready = 1'b0;
    in_valid = 1'b1; a_v = pk(9, 9, 9); b_v = '0; th_v = 10'd0;
    step();
    a_v = pk(7, 7, 7);
    step();
    in_valid = 1'b0;
    check("pre_rst_inrdy", if0.in_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", if0.out_valid, 1'b0);
    check("arst_cnt", if0.fg_count, 20'd0);
    check("arst_in_ready", if0.in_ready, 1'b1);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("arst_stale", if0.out_valid, 1'b0);
      step();
    end

    // Counter clear
    beat(pk(1, 1, 1), pk(0, 0, 0), 10'd0);
    step();
    check("clr_pre", if2.fg_count, 2'd1);
    beat(pk(1, 1, 1), pk(0, 0, 0), 10'd0);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("clr_xfer0", if0.fg_count, 20'd1);
    check("clr_xfer2", if2.fg_count, 2'd1);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("clr_alone", if0.fg_count, 20'd0);

    // Directed backpressure: 6 beats, out_ready low in cycles 3..7
    sent = 0; rx = 0; stall_prev = 1'b0; prev = '0;
    q.delete();
    for (int cyc = 0; cyc < 40 && rx < 6; cyc++) begin
      in_valid = (sent < 6);
      a_v = pk(5 + 40 * sent, 17 * sent, 200 - sent);
      b_v = pk(10 * sent, 100, sent);
      th_v = 10'd300;
      out_ready = !(cyc >= 3 && cyc <= 7);
      @(negedge clk);
      if (cyc <= 2) check("bp_inrdy_hi", if0.in_ready, 1'b1);
      if (cyc >= 3 && cyc <= 7) check("bp_inrdy_lo", if0.in_ready, 1'b0);
      if (stall_prev) check("bp_hold", {if0.out_valid, obs_beat()}, {1'b1, prev});
      acc = in_valid & if0.in_ready;
      if (acc) begin
        q.push_back(ref_beat(a_v, b_v, th_v));
        sent++;
      end
      if (if0.out_valid && out_ready) begin
        if (q.size() == 0) check("bp_extra", 1'b1, 1'b0);
        else check("bp_beat", obs_beat(), q.pop_front());
        rx++;
      end
      stall_prev = if0.out_valid & !out_ready;
      prev = obs_beat();
      step();
    end
    in_valid = 1'b0;
    check("bp_rx", rx, 6);

    // Random valid/ready against the reference queue
    sent = 0; rx = 0; stall_prev = 1'b0; acc = 1'b1;
    q.delete();
    for (int cyc = 0; cyc < 80000 && rx < 10000; cyc++) begin
      if (!in_valid || acc) begin
        if (sent < 10000 && $urandom_range(0, 99) < 70) begin
          in_valid = 1'b1;
          a_v = 24'($urandom);
          b_v = 24'($urandom);
          th_v = 10'($urandom_range(0, 800));
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 99) < 60);
      @(negedge clk);
      if (stall_prev) check("rnd_hold", {if0.out_valid, obs_beat()}, {1'b1, prev});
      acc = in_valid & if0.in_ready;
      if (acc) begin
        q.push_back(ref_beat(a_v, b_v, th_v));
        sent++;
      end
      if (if0.out_valid && out_ready) begin
        if (q.size() == 0) check("rnd_extra", 1'b1, 1'b0);
        else check("rnd_beat", obs_beat(), q.pop_front());
        rx++;
      end
      stall_prev = if0.out_valid & !out_ready;
      prev = obs_beat();
      step();
    end
    in_valid = 1'b0;
    check("rnd_rx", rx, 10000);
    check("rnd_left", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/abs_diff_pipe.md
Name: abs_diff_pipe

Overview:
Multi-channel, pipelined absolute-difference unit for the background model. It computes the per-channel |a-b| over CHANNELS unsigned samples and reduces them to one distance, either the L1 sum or the channel maximum. The distance is compared against a per-pixel threshold to produce a foreground flag, and a saturating counter tracks foreground pixels per frame. Valid/ready streaming on both sides with full backpressure; it sits between the pixel/background-fetch stream and the model-update logic.

Parameters:
WIDTH, 8, bits per channel sample (unsigned)
CHANNELS, 3, channels per pixel; channel 0 at LSBs of packed buses
MODE, 0, distance reduction: 0 = sum of channel differences (L1), 1 = maximum channel difference
CNT_W, 20, width of foreground pixel counter
(localparam SUM_W = WIDTH + $clog2(CHANNELS), equals WIDTH when CHANNELS = 1)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid & in_ready
in_a  in  CHANNELS*WIDTH  packed samples A (current pixel)
in_b  in  CHANNELS*WIDTH  packed samples B (background)
in_thresh  in  SUM_W  foreground threshold, travels with its beat
out_valid  out  1  output beat valid
out_ready  in  1  downstream accept
out_diff  out  CHANNELS*WIDTH  packed per-channel |a-b|
out_dist  out  SUM_W  reduced distance
out_fg  out  1  1 when out_dist > thresh of this beat
cnt_clr  in  1  synchronous clear of fg_count
fg_count  out  CNT_W  saturating count of transferred beats with out_fg=1

Behaviour:
- Reset (rst_n low, asynchronous): both stage valids, out_valid, out_diff, out_dist, out_fg and fg_count all go to 0. Reset mid-stream discards in-flight beats. in_ready is 1 after reset.
- Stage 1, on accept: per-channel diff = (a>=b) ? a-b : b-a, which is exact in WIDTH bits with no wrap. Diffs and thresh are registered.
- Stage 2: reduce. MODE 0 is a full-width sum in SUM_W bits with no overflow possible. MODE 1 is the max, zero-extended to SUM_W. The flag is fg = dist > thresh, a strict compare. dist, fg and the diffs are registered to the outputs.
- Latency is 2 cycles from accept to out_valid when there is no backpressure. Throughput is 1 beat per cycle.
- Handshake:
  - adv2 = !out_valid | out_ready
  - adv1 = !s1_valid | adv2
  - in_ready = adv1, which is combinational from out_ready; no combinational path from in_valid to in_ready.
- Stalled stages hold data stable. out_* must not change while out_valid=1 and out_ready=0. A beat is never dropped or duplicated, and order is preserved.
- Stage bubbles collapse: with out_ready low, the pipe fills to exactly 2 beats, then in_ready drops.
- fg_count increments on each output transfer (out_valid & out_ready) with out_fg=1 and saturates at 2^CNT_W-1.
- cnt_clr has priority over the increment. If cnt_clr coincides with a counted transfer, fg_count becomes 1; otherwise it becomes 0.
- Data registers may be left unreset; valid bits and fg_count must be reset.

Test Plan:
1. Reset: assert rst_n=0 asynchronously mid-cycle with 2 beats in flight -> out_valid=0, fg_count=0, in_ready=1 immediately. After release, no stale beat emerges.
2. Basic (CHANNELS=3, MODE 0, out_ready=1): a={10,200,50}, b={30,100,50}, thresh=100 -> 2 cycles later out_diff={20,100,0}, out_dist=120, out_fg=1, fg_count=1.
3. Boundary: a=255, b=0 on all channels, thresh=765 -> diff=255 each, out_dist=765 (10 bits), out_fg=0. Repeat with thresh=764 -> out_fg=1. Repeat with a=0, b=255 -> identical.
4. Backpressure: stream 6 back-to-back beats, out_ready low for cycles 3-7 -> in_ready low once 2 beats are held. Outputs stable while stalled; all 6 beats arrive in order, none lost or duplicated. Also random in_valid/out_ready for 10k beats vs a reference model.
5. MODE 1: inputs of scenario 2 with thresh=100 -> out_dist=100, out_fg=0. With thresh=99 -> out_fg=1.
6. Counter (CNT_W=2): 5 fg transfers -> fg_count saturates at 3. cnt_clr coincident with an fg transfer -> 1. cnt_clr alone -> 0.
